// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: BCD HH:MM:SS timekeeper with digit-set editing and 4-digit display mux.
// Optional blink of the edited digit is enabled by defining CLOCK_BLINK_EN.
module clock_time_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_sec,
  input  logic       key_inc,
  input  logic       HHMM_view,
  input  logic       MMSS_view,
  input  logic [5:0] sel_set,
  output logic [3:0] h1,
  output logic [3:0] h2,
  output logic [3:0] m1,
  output logic [3:0] m2,
  output logic [3:0] s1,
  output logic [3:0] s2,
  output logic [3:0] disp3,
  output logic [3:0] disp2,
  output logic [3:0] disp1,
  output logic [3:0] disp0,
  output logic [3:0] disp_blank,
  output logic       day_wrap
);
  typedef enum logic [1:0] {RUN, EDIT, HOLD} state_t;
  state_t state_d, state_q;
  logic [3:0] h1_d, h1_q, h2_d, h2_q, m1_d, m1_q, m2_d, m2_q, s1_d, s1_q, s2_d, s2_q;
  logic [5:0] sel_d, sel_q;
  logic hhmm_d, hhmm_q, mmss_d, mmss_q;
  logic [15:0] disp_d, disp_q;
  logic [3:0] blank_d, blank_q;
  logic day_wrap_d, day_wrap_q;
  logic run_tick, edit_key, c_s2, c_s1, c_m2, c_m1, c_h2, c_day, show_hm, show_ms;
  function automatic logic [3:0] inc(input logic [3:0] d, input logic [3:0] lim);
    return d >= lim ? 4'd0 : d + 4'd1;
  endfunction
  always_comb begin
    state_d = sel_set == 6'd0 ? RUN : (sel_set & (sel_set - 6'd1)) == 6'd0 ? EDIT : HOLD;
    sel_d = sel_set;
    hhmm_d = HHMM_view;
    mmss_d = MMSS_view;
  end
  always_comb begin
    run_tick = state_d == RUN && tick_sec;
    edit_key = state_d == EDIT && key_inc;
    c_s2 = run_tick && s2_q == 4'd9;
    c_s1 = c_s2 && s1_q == 4'd5;
    c_m2 = c_s1 && m2_q == 4'd9;
    c_m1 = c_m2 && m1_q == 4'd5;
    c_h2 = c_m1 && h2_q == 4'd9;
    c_day = c_m1 && h1_q == 4'd2 && h2_q == 4'd3;
  end
  // Edits wrap the chosen digit only; raising h1 to 2 clamps h2 so 24:xx..29:xx never appear
  always_comb begin
    h1_d = h1_q;
    h2_d = h2_q;
    m1_d = m1_q;
    m2_d = m2_q;
    s1_d = s1_q;
    s2_d = s2_q;
    day_wrap_d = 1'b0;
    if (run_tick) begin
      s2_d = inc(s2_q, 4'd9);
      if (c_s2) s1_d = inc(s1_q, 4'd5);
      if (c_s1) m2_d = inc(m2_q, 4'd9);
      if (c_m2) m1_d = inc(m1_q, 4'd5);
      if (c_m1) h2_d = c_day ? 4'd0 : inc(h2_q, 4'd9);
      if (c_h2) h1_d = h1_q + 4'd1;
      if (c_day) h1_d = 4'd0;
      day_wrap_d = c_day;
    end else if (edit_key) begin
      if (sel_set[5]) begin
        h1_d = inc(h1_q, 4'd2);
        if (h1_d == 4'd2 && h2_q > 4'd3) h2_d = 4'd3;
      end
      if (sel_set[4]) h2_d = inc(h2_q, h1_q == 4'd2 ? 4'd3 : 4'd9);
      if (sel_set[3]) m1_d = inc(m1_q, 4'd5);
      if (sel_set[2]) m2_d = inc(m2_q, 4'd9);
      if (sel_set[1]) s1_d = inc(s1_q, 4'd5);
      if (sel_set[0]) s2_d = inc(s2_q, 4'd9);
    end
  end
`ifdef CLOCK_BLINK_EN
  logic phase_d, phase_q;
  always_comb
    phase_d = state_d == EDIT && (state_q != EDIT || key_inc) ? 1'b0 :
              state_d == EDIT && tick_sec ? !phase_q : phase_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) phase_q <= 1'b0;
    else phase_q <= phase_d;
`endif
  // Display works from the registered digits and selects, one stage behind the time
  always_comb begin
    show_hm = state_q == EDIT ? |sel_q[5:2] : state_q == RUN && hhmm_q;
    show_ms = state_q == EDIT ? |sel_q[1:0] : state_q == RUN && !hhmm_q && mmss_q;
    disp_d = show_hm ? {h1_q, h2_q, m1_q, m2_q} : show_ms ? {m1_q, m2_q, s1_q, s2_q} : 16'h0;
    blank_d = show_hm || show_ms ? 4'b0000 : 4'b1111;
`ifdef CLOCK_BLINK_EN
    if (phase_q && state_q == EDIT)
      blank_d = blank_d | {sel_q[5], sel_q[4], sel_q[3] | sel_q[1], sel_q[2] | sel_q[0]};
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      {h1_q, h2_q, m1_q, m2_q, s1_q, s2_q} <= 24'h0;
      sel_q <= 6'd0;
      hhmm_q <= 1'b0;
      mmss_q <= 1'b0;
      disp_q <= 16'h0;
      blank_q <= 4'h0;
      day_wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      {h1_q, h2_q, m1_q, m2_q, s1_q, s2_q} <= {h1_d, h2_d, m1_d, m2_d, s1_d, s2_d};
      sel_q <= sel_d;
      hhmm_q <= hhmm_d;
      mmss_q <= mmss_d;
      disp_q <= disp_d;
      blank_q <= blank_d;
      day_wrap_q <= day_wrap_d;
    end
  assign {h1, h2, m1, m2, s1, s2} = {h1_q, h2_q, m1_q, m2_q, s1_q, s2_q};
  assign {disp3, disp2, disp1, disp0} = disp_q;
  assign disp_blank = blank_q;
  assign day_wrap = day_wrap_q;
endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: directed + random checks against a seconds-of-day reference model.
module tb_clock_time_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, tick_sec = 1'b0, key_inc = 1'b0, HHMM_view = 1'b0, MMSS_view = 1'b0;
  logic [5:0] sel_set = 6'd0;
  logic [3:0] h1, h2, m1, m2, s1, s2, disp3, disp2, disp1, disp0, disp_blank;
  logic day_wrap;
  int n_chk = 0, n_fail = 0;
  int t, st_r, phase;
  logic [5:0] sel_r;
  logic hv_r, mv_r, dw_m;
  logic [15:0] disp_m;
  logic [3:0] blank_m;
  logic [23:0] saved;
  clock_time_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick_sec(tick_sec), .key_inc(key_inc),
    .HHMM_view(HHMM_view), .MMSS_view(MMSS_view), .sel_set(sel_set),
    .h1(h1), .h2(h2), .m1(m1), .m2(m2), .s1(s1), .s2(s2),
    .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0),
    .disp_blank(disp_blank), .day_wrap(day_wrap)
  );
  always #5 clk = ~clk;
  function automatic logic [23:0] bcd(input int sec);
    int h, m, s;
    h = sec / 3600;
    m = (sec / 60) % 60;
    s = sec % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    t = 0; st_r = 0; phase = 0; sel_r = 6'd0; hv_r = 1'b0; mv_r = 1'b0;
    dw_m = 1'b0; disp_m = 16'h0; blank_m = 4'h0;
  endtask
  task automatic check_all();
    chk("time", {h1, h2, m1, m2, s1, s2}, bcd(t));
    chk("disp", {disp3, disp2, disp1, disp0}, disp_m);
    chk("blank", disp_blank, blank_m);
    chk("day_wrap", day_wrap, dw_m);
  endtask
  task automatic model_edge(input logic tk, input logic ky, input logic [5:0] sl, input logic hv, input logic mv);
    int st, idx, lim, np;
    int dg[6];
    logic [23:0] d;
    logic [15:0] nd;
    logic [3:0] nb;
    st = sl == 0 ? 0 : ($countones(sl) == 1 ? 1 : 2);
    d = bcd(t);
    nd = 16'h0;
    nb = 4'hf;
    if ((st_r == 1 && sel_r[5:2] != 0) || (st_r == 0 && hv_r)) begin nd = d[23:8]; nb = 4'h0; end
    else if (st_r == 1 || (st_r == 0 && mv_r)) begin nd = d[15:0]; nb = 4'h0; end
    np = phase;
`ifdef CLOCK_BLINK_EN
    if (phase == 1 && st_r == 1)
      for (int i = 0; i < 6; i++) if (sel_r[5 - i]) nb[3 - (i < 4 ? i : i - 2)] = 1'b1;
    if (st == 1) np = (st_r != 1 || ky) ? 0 : (tk ? 1 - phase : phase);
`endif
    dw_m = 1'b0;
    if (st == 0 && tk) begin
      dw_m = t == 86399;
      t = (t + 1) % 86400;
    end else if (st == 1 && ky) begin
      for (int i = 0; i < 6; i++) dg[i] = int'(d[23 - 4 * i -: 4]);
      idx = 0;
      for (int i = 0; i < 6; i++) if (sl[5 - i]) idx = i;
      lim = idx == 0 ? 2 : idx == 1 ? (dg[0] == 2 ? 3 : 9) : (idx == 2 || idx == 4) ? 5 : 9;
      dg[idx] = dg[idx] >= lim ? 0 : dg[idx] + 1;
      if (idx == 0 && dg[0] == 2 && dg[1] > 3) dg[1] = 3;
      t = ((dg[0] * 10 + dg[1]) * 60 + dg[2] * 10 + dg[3]) * 60 + dg[4] * 10 + dg[5];
    end
    disp_m = nd; blank_m = nb; phase = np;
    st_r = st; sel_r = sl; hv_r = hv; mv_r = mv;
  endtask
  task automatic step(input logic tk, input logic ky, input logic [5:0] sl, input logic hv, input logic mv);
    tick_sec = tk; key_inc = ky; sel_set = sl; HHMM_view = hv; MMSS_view = mv;
    @(posedge clk);
    #1;
    model_edge(tk, ky, sl, hv, mv);
    check_all();
  endtask
  task automatic set_to(input int i, input int v);
    logic [23:0] d;
    for (int k = 0; k < 12; k++) begin
      d = bcd(t);
      if (int'(d[23 - 4 * i -: 4]) == v) break;
      step(1'b0, 1'b1, 6'(1 << (5 - i)), 1'b0, 1'b0);
    end
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    for (int i = 0; i < 61; i++) step(1'b1, 1'b0, 6'd0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    chk("run_61_time", {h1, h2, m1, m2, s1, s2}, 24'h000101);
    chk("run_61_disp", {disp3, disp2, disp1, disp0}, 16'h0101);
    set_to(0, 2); set_to(1, 3); set_to(2, 5); set_to(3, 9); set_to(4, 5); set_to(5, 9);
    chk("preload", {h1, h2, m1, m2, s1, s2}, 24'h235959);
    step(1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
    chk("wrap_time", {h1, h2, m1, m2, s1, s2}, 24'h000000);
    chk("wrap_pulse", day_wrap, 1'b1);
    step(1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
    chk("wrap_pulse_end", day_wrap, 1'b0);
    set_to(0, 1); set_to(1, 9);
    step(1'b0, 1'b1, 6'b100000, 1'b0, 1'b0);
    chk("h1_clamp", {h1, h2}, 8'h23);
    step(1'b0, 1'b1, 6'b100000, 1'b0, 1'b0);
    chk("h1_wrap", {h1, h2}, 8'h03);
    set_to(2, 5);
    saved = {h1, h2, m1, m2, s1, s2};
    step(1'b1, 1'b1, 6'b001000, 1'b0, 1'b1);
    chk("m1_key_wins", {h1, h2, m1, m2, s1, s2}, {saved[23:16], 4'h0, saved[11:0]});
    repeat (2) step(1'b0, 1'b0, 6'b001000, 1'b0, 1'b1);
    chk("edit_disp_hm", {disp3, disp2, disp1, disp0}, {h1, h2, m1, m2});
    saved = {h1, h2, m1, m2, s1, s2};
    step(1'b1, 1'b1, 6'b110000, 1'b1, 1'b0);
    chk("hold_time", {h1, h2, m1, m2, s1, s2}, saved);
    repeat (2) step(1'b0, 1'b0, 6'b110000, 1'b1, 1'b0);
    chk("hold_blank", disp_blank, 4'b1111);
    chk("hold_disp", {disp3, disp2, disp1, disp0}, 16'h0);
`ifdef CLOCK_BLINK_EN
    step(1'b0, 1'b0, 6'b000001, 1'b0, 1'b1);
    step(1'b1, 1'b0, 6'b000001, 1'b0, 1'b1);
    step(1'b1, 1'b0, 6'b000001, 1'b0, 1'b1);
    chk("blink_on", disp_blank, 4'b0001);
    step(1'b0, 1'b0, 6'b000001, 1'b0, 1'b1);
    chk("blink_off", disp_blank, 4'b0000);
    step(1'b1, 1'b0, 6'b000001, 1'b0, 1'b1);
    step(1'b0, 1'b1, 6'b000001, 1'b0, 1'b1);
    step(1'b0, 1'b0, 6'b000001, 1'b0, 1'b1);
    chk("blink_key_clear", disp_blank, 4'b0000);
`endif
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [5:0] sl;
      r = int'($urandom_range(0, 9));
      sl = r < 5 ? 6'd0 : r < 9 ? 6'(1 << $urandom_range(0, 5)) : 6'($urandom);
      if (n == 300) begin
        tick_sec = 1'b1; key_inc = 1'b1; sel_set = 6'b100000;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
      end
      step(1'($urandom), 1'($urandom), sl, 1'($urandom), 1'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/clock_time_ctrl.md
# clock_time_ctrl

BCD timekeeping controller for the digital clock. Counts HH:MM:SS from a 1 Hz tick in run mode, and freezes counting in set mode. In set mode it applies increment pulses to the single digit selected by the clock state machine, enforcing per-digit limits, and drives the four-digit display mux from the view/set selects.

## Interface
Parameters:
- none (24 h format fixed)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- tick_sec  in  1  one-cycle pulse per second
- key_inc  in  1  one-cycle increment pulse, debounced upstream
- HHMM_view  in  1  show hours:minutes
- MMSS_view  in  1  show minutes:seconds
- sel_set  in  6  set-digit selects {S_H1,S_H2,S_M1,S_M2,S_S1,S_S2}; one-hot or zero
- h1,h2,m1,m2,s1,s2  out  4 each  current time BCD digits, registered
- disp3..disp0  out  4 each  display digits, disp3 leftmost, registered
- disp_blank  out  4  per-digit blank, bit3 = disp3
- day_wrap  out  1  one-cycle pulse on 23:59:59 -> 00:00:00

## Operation
- Controller states:
  - RUN (sel_set == 0)
  - EDIT (sel_set one-hot)
  - HOLD (more than one sel_set bit set)
- The state is re-evaluated every cycle from sel_set. Any state may go to any state.
- RUN:
  - On tick_sec, s2 increments.
  - BCD carry chain: s2 9->0 carries s1; s1 5->0 carries m2; m2 9->0 carries m1; m1 5->0 carries h2; h2 9->0 carries h1.
  - At 23:59:59, a tick gives 00:00:00 and day_wrap = 1 for that cycle.
  - key_inc is ignored.
- EDIT:
  - tick_sec does not change the time.
  - Each key_inc increments only the selected digit, with wrap to 0 and no carry.
  - Digit limits: h1 0..2; h2 0..9 when h1 < 2, otherwise 0..3; m1 0..5; m2 0..9; s1 0..5; s2 0..9.
  - If h1 is incremented to 2 while h2 > 3, h2 is forced to 3 in the same cycle.
- HOLD: time is frozen, and both key_inc and tick_sec are ignored.
- Display source:
  - EDIT with H1/H2/M1/M2 selected: h1,h2,m1,m2.
  - EDIT with S1/S2 selected: m1,m2,s1,s2.
  - Otherwise, if HHMM_view = 1: h1,h2,m1,m2.
  - Otherwise, if MMSS_view = 1: m1,m2,s1,s2.
  - Otherwise, and in HOLD: all disp = 4'h0 and disp_blank = 4'b1111.
  - HHMM_view has priority if both views are set.
- Leaving EDIT for RUN resumes counting at the next tick_sec. There is no sub-second realignment.

## Timing
- Reset values: all time digits 0; disp3..disp0 = 0; disp_blank = 0; day_wrap = 0; state RUN; blink phase 0.
- Reset is asynchronous and may assert mid-edit or mid-carry. All registers go to their reset values immediately.
- Time update: a tick_sec or key_inc sampled at edge n updates the digits at edge n+1.
- Display update: disp/disp_blank reflect new digits or selects at edge n+2, one register stage after the digits.
- day_wrap is asserted in the same cycle the digits show 00:00:00.
- tick_sec and key_inc in the same cycle: in RUN the tick is applied; in EDIT the key_inc is applied; in HOLD neither.
- A sel_set change in the same cycle as key_inc: the new sel_set decides the state and the target digit.

## Configuration
- Macro: CLOCK_BLINK_EN.
- Defined:
  - A blink phase bit toggles on every tick_sec while in EDIT.
  - The phase is cleared on entry to EDIT and on every key_inc.
  - While phase = 1, the disp_blank bit of the edited digit's display position is 1.
- Undefined: no blink register; disp_blank is nonzero only in the all-blank case.

## Test plan
- Reset, then 61 tick_sec in RUN with HHMM_view = 0, MMSS_view = 1 -> time 00:01:01; disp = 0,1,0,1 two cycles after the last tick.
- Preload 23:59:59 via EDIT, return to RUN, one tick -> 00:00:00; day_wrap high exactly one cycle.
- Time 19:00:00, EDIT S_H1, one key_inc -> h1 = 2, h2 = 3; a further key_inc -> h1 = 0, h2 = 3.
- EDIT S_M1 at m1 = 5, key_inc together with tick_sec -> m1 = 0, seconds unchanged; disp shows h1,h2,m1,m2.
- sel_set = 6'b110000, apply key_inc and tick_sec -> time unchanged, disp_blank = 4'b1111.
- CLOCK_BLINK_EN defined, EDIT S_S2 on MMSS display, two ticks -> disp_blank = 4'b0001 then 4'b0000; key_inc clears it to 0 the next cycle.
